tensor_stream_tx: RTL

TENSOR_STREAM_TX -- requirements
Module: tensor_stream_tx

---
 rtl/conv2d_pkg.sv | 15 +
 rtl/tensor_stream_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d tensor datapath blocks.
// Holds the stream-transmitter FSM encoding and the default element width.
// No logic; imported by the blocks that use these types.
package conv2d_pkg;

  // Transmitter FSM encoding: IDLE=0, SEND=1, DONE=2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/tensor_stream_tx.sv
// Purpose: snapshots a flat tensor on start and streams it out one element per beat.
// Latency: first beat 1 cycle after the start edge; done 1 cycle after the last beat.
// Backpressure: valid/ready; beat fields hold while m_ready is low, start ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             capture tensor_flat and begin streaming (honoured in IDLE only)
//   tensor_flat       NUM_ELEMS elements, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy              high in SEND and DONE
//   m_valid/m_ready   stream handshake
//   m_data/m_index    current element and its flat index (0 when not sending)
//   m_last            high on the beat carrying index NUM_ELEMS-1
//   done              one-cycle pulse after the last beat is accepted
module tensor_stream_tx
  import conv2d_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  NUM_ELEMS  = 4,
  localparam int IDX_WIDTH  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0] tensor_flat,
  output logic                            busy,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [IDX_WIDTH-1:0]            m_index,
  output logic                            m_last,
  output logic                            done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

  tx_state_t                       state;
  logic [IDX_WIDTH-1:0]            idx;
  logic [IDX_WIDTH-1:0]            next_idx;
  logic [NUM_ELEMS*DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0]           next_data;

  // Only consumed on a non-last transfer, so it never runs past LAST_IDX.
  assign next_idx = idx + IDX_WIDTH'(1);

  // Element mux for the beat that follows the current one. Outputs are
  // registered, so the next element is selected one transfer ahead.
  always_comb begin
    next_data = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (next_idx == IDX_WIDTH'(i)) begin
        next_data = shadow[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shadow  <= '0;
      busy    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= tensor_flat;
            idx     <= '0;
            state   <= SEND;
            busy    <= 1'b1;
            m_valid <= 1'b1;
            m_data  <= tensor_flat[DATA_WIDTH-1:0];
            m_index <= '0;
            m_last  <= (NUM_ELEMS == 1);
          end
        end

        // m_valid is held high for the whole of SEND, so m_ready alone
        // qualifies a transfer here.
        SEND: begin
          if (m_ready) begin
            if (m_last) begin
              state   <= DONE;
              m_valid <= 1'b0;
              m_data  <= '0;
              m_index <= '0;
              m_last  <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx     <= next_idx;
              m_data  <= next_data;
              m_index <= next_idx;
              m_last  <= (next_idx == LAST_IDX);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          idx     <= '0;
          busy    <= 1'b0;
          m_valid <= 1'b0;
          m_data  <= '0;
          m_index <= '0;
          m_last  <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
